// File: rtl/interconnect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interconnect_pkg
// Description : Shared constants and types for the global-memory interconnect:
//               PE / bank counts, bank geometry, read latency, reset level
//               and the PE / bank identifier types.
// Revision    : 1.0 - initial release
// ============================================================================
package interconnect_pkg;

  // System geometry
  localparam int N_PE                       = 4;
  localparam int N_GLOBAL_MEM_BANKS         = 4;
  localparam int GLOBAL_MEM_PER_BANK_ADDR_L = 10;
  localparam int GLOBAL_MEM_RD_LATENCY      = 2;

  // Level of rst that holds the interconnect in reset (active-low)
  localparam logic RESET_STATE = 1'b0;

  typedef logic [$clog2(N_GLOBAL_MEM_BANKS)-1:0] bank_id_t;
  typedef logic [$clog2(N_PE)-1:0]               pe_id_t;

endpackage : interconnect_pkg
`default_nettype wire

// File: rtl/interconnect_rr_arbiter_per_bank.sv
`default_nettype none
// ============================================================================
// Module      : interconnect_rr_arbiter_per_bank
// Description : Arbiter for one global-memory bank. Priority is
//               block (init) > owning PE's store > round-robin among loads.
//               Owns the bank's round-robin pointer.
// Ports       : clk, rst        - clock, async active-low reset
//               req_mask        - PEs requesting a load from this bank
//               st_req          - store request of the owning PE
//               block           - host init access holds this bank
//               gnt_onehot      - load grant, one-hot over PEs
//               winner_id       - PE served (pointer value when none)
//               st_gnt          - owning PE's store granted
//               grant_out       - bank serves a PE store or load
// Revision    : 1.0 - initial release
// ============================================================================
module interconnect_rr_arbiter_per_bank
  import interconnect_pkg::*;
#(
  parameter int N_PE     = 4,
  parameter int BANK_IDX = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_PE-1:0]         req_mask,
  input  logic                    st_req,
  input  logic                    block,
  output logic [N_PE-1:0]         gnt_onehot,
  output logic [$clog2(N_PE)-1:0] winner_id,
  output logic                    st_gnt,
  output logic                    grant_out
);

  localparam int                c_id_w   = $clog2(N_PE);
  localparam logic [c_id_w-1:0] c_own_id = c_id_w'(BANK_IDX);

  logic [c_id_w-1:0] r_ptr;
  logic [c_id_w-1:0] w_cand;
  logic [c_id_w-1:0] w_winner;
  logic              w_found;
  logic              w_ld_win;
  logic [N_PE-1:0]   w_gnt_onehot;
  logic              w_st_gnt;

  // Search starts at the pointer and wraps; N_PE is a power of two, so the
  // natural overflow of the id-width adder performs the modulo.
  always_comb begin
    w_cand       = r_ptr;
    w_winner     = r_ptr;
    w_found      = 1'b0;
    w_ld_win     = 1'b0;
    w_st_gnt     = 1'b0;
    w_gnt_onehot = '0;
    if (!block) begin
      if (st_req) begin
        w_st_gnt = 1'b1;
        w_winner = c_own_id;
      end else begin
        for (int i = 0; i < N_PE; i++) begin
          w_cand = r_ptr + c_id_w'(i);
          if (!w_found && req_mask[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
          end
        end
        if (w_found) begin
          w_ld_win               = 1'b1;
          w_gnt_onehot[w_winner] = 1'b1;
        end
      end
    end
  end

  // Pointer moves only on a load grant, to the PE after the winner
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET_STATE) begin
      r_ptr <= '0;
    end else if (w_ld_win) begin
      r_ptr <= w_winner + c_id_w'(1);
    end
  end

  assign gnt_onehot = w_gnt_onehot;
  assign winner_id  = w_winner;
  assign st_gnt     = w_st_gnt;
  assign grant_out  = w_st_gnt | w_ld_win;

endmodule : interconnect_rr_arbiter_per_bank
`default_nettype wire

// File: rtl/interconnect_ld_st_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : interconnect_ld_st_arbiter
// Description : Per-bank load/store arbitration in front of the interconnect
//               datapath. Grants are combinational (zero latency); pointers
//               and the load-stall counter update on posedge clk.
// Ports       : clk, rst              - clock, async active-low reset
//               ld_req, ld_mem_bank_id - per-PE load request and target bank
//               st_req                 - per-PE store request (PE i -> bank i)
//               init_mem_vld, init_bank_id - host init access, blocks a bank
//               ld_gnt, st_gnt         - per-PE grants
//               granted_requester_id   - winning PE per bank
//               grant_out_port_wise    - bank serves a PE this cycle
//               perf_clr, ld_stall_cnt - stall counter clear / value
// Revision    : 1.0 - initial release
// ============================================================================
module interconnect_ld_st_arbiter
  import interconnect_pkg::*;
#(
  parameter int N_PE       = interconnect_pkg::N_PE,
  parameter int N_BANKS    = interconnect_pkg::N_GLOBAL_MEM_BANKS,
  parameter int PERF_CNT_L = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [N_PE-1:0]                         ld_req,
  input  logic [N_PE-1:0][$clog2(N_BANKS)-1:0]    ld_mem_bank_id,
  input  logic [N_PE-1:0]                         st_req,
  input  logic                                    init_mem_vld,
  input  logic [$clog2(N_BANKS)-1:0]              init_bank_id,
  output logic [N_PE-1:0]                         ld_gnt,
  output logic [N_PE-1:0]                         st_gnt,
  output logic [N_BANKS-1:0][$clog2(N_PE)-1:0]    granted_requester_id,
  output logic [N_BANKS-1:0]                      grant_out_port_wise,
  input  logic                                    perf_clr,
  output logic [PERF_CNT_L-1:0]                   ld_stall_cnt
);

  localparam int c_bank_w = $clog2(N_BANKS);

  if (N_BANKS != N_PE) begin : g_bad_cfg
    $error("interconnect_ld_st_arbiter: N_BANKS must equal N_PE");
  end

  logic [N_BANKS-1:0][N_PE-1:0] w_req_mask;
  logic [N_BANKS-1:0][N_PE-1:0] w_gnt_bank;
  logic [N_BANKS-1:0]           w_block;
  logic [N_PE-1:0]              w_ld_gnt;
  logic                         w_stall;
  logic [PERF_CNT_L-1:0]        r_ld_stall_cnt;

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    for (genvar k = 0; k < N_PE; k++) begin : g_pe
      assign w_req_mask[b][k] = ld_req[k] &&
                                (ld_mem_bank_id[k] == c_bank_w'(b));
    end

    assign w_block[b] = init_mem_vld && (init_bank_id == c_bank_w'(b));

    interconnect_rr_arbiter_per_bank #(
      .N_PE     (N_PE),
      .BANK_IDX (b)
    ) u_arb (
      .clk        (clk),
      .rst        (rst),
      .req_mask   (w_req_mask[b]),
      .st_req     (st_req[b]),
      .block      (w_block[b]),
      .gnt_onehot (w_gnt_bank[b]),
      .winner_id  (granted_requester_id[b]),
      .st_gnt     (st_gnt[b]),
      .grant_out  (grant_out_port_wise[b])
    );

    a_one_per_bank : assert property (@(posedge clk)
      disable iff (rst == RESET_STATE) !(st_gnt[b] && (|w_gnt_bank[b])));
  end

  // A PE targets a single bank, so at most one bank sets its bit
  always_comb begin
    w_ld_gnt = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      w_ld_gnt = w_ld_gnt | w_gnt_bank[b];
    end
  end

  assign ld_gnt  = w_ld_gnt;
  assign w_stall = |(ld_req & ~w_ld_gnt);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET_STATE) begin
      r_ld_stall_cnt <= '0;
    end else if (perf_clr) begin
      r_ld_stall_cnt <= '0;
    end else if (w_stall && (r_ld_stall_cnt != '1)) begin
      r_ld_stall_cnt <= r_ld_stall_cnt + PERF_CNT_L'(1);
    end
  end

  assign ld_stall_cnt = r_ld_stall_cnt;

  a_ld_gnt_subset : assert property (@(posedge clk)
    disable iff (rst == RESET_STATE) (ld_gnt & ~ld_req) == '0);

endmodule : interconnect_ld_st_arbiter
`default_nettype wire

// File: tb/tb_interconnect_ld_st_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_interconnect_ld_st_arbiter
// Description : Scoreboard bench for interconnect_ld_st_arbiter with
//               N_PE = N_BANKS = 4 and a 4-bit stall counter. The driver
//               applies directed then random stimulus and pushes the model's
//               expected outputs; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interconnect_ld_st_arbiter;

  typedef struct packed {
    logic [3:0] ld;
    logic [3:0] st;
    logic [3:0] gop;
    logic [7:0] rid;
    logic [3:0] cnt;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [3:0]      ld_req;
  logic [3:0][1:0] ld_mem_bank_id;
  logic [3:0]      st_req;
  logic            init_mem_vld;
  logic [1:0]      init_bank_id;
  logic [3:0]      ld_gnt;
  logic [3:0]      st_gnt;
  logic [3:0][1:0] granted_requester_id;
  logic [3:0]      grant_out_port_wise;
  logic            perf_clr;
  logic [3:0]      ld_stall_cnt;

  interconnect_ld_st_arbiter #(
    .N_PE       (4),
    .N_BANKS    (4),
    .PERF_CNT_L (4)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ld_req               (ld_req),
    .ld_mem_bank_id       (ld_mem_bank_id),
    .st_req               (st_req),
    .init_mem_vld         (init_mem_vld),
    .init_bank_id         (init_bank_id),
    .ld_gnt               (ld_gnt),
    .st_gnt               (st_gnt),
    .granted_requester_id (granted_requester_id),
    .grant_out_port_wise  (grant_out_port_wise),
    .perf_clr             (perf_clr),
    .ld_stall_cnt         (ld_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state: round-robin pointer per bank and the stall count
  int   m_ptr[4];
  int   m_cnt;

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs have settled since the driver moved at posedge+1
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("ld_gnt",   {4'h0, ld_gnt},              {4'h0, e.ld});
      check("st_gnt",   {4'h0, st_gnt},              {4'h0, e.st});
      check("grant_op", {4'h0, grant_out_port_wise}, {4'h0, e.gop});
      check("req_id",   granted_requester_id,        e.rid);
      check("stall",    {4'h0, ld_stall_cnt},        {4'h0, e.cnt});
    end
  end

  // Apply one cycle of inputs, predict the outputs, advance the model
  task automatic step(input logic r, input logic [3:0] lr,
                      input logic [7:0] bid, input logic [3:0] sr,
                      input logic iv, input logic [1:0] ib, input logic pc);
    exp_t e;
    int   best;
    int   bestd;
    int   d;
    int   new_ptr[4];
    rst            = r;
    ld_req         = lr;
    ld_mem_bank_id = bid;
    st_req         = sr;
    init_mem_vld   = iv;
    init_bank_id   = ib;
    perf_clr       = pc;
    if (!r) begin
      for (int b = 0; b < 4; b++) m_ptr[b] = 0;
      m_cnt = 0;
    end
    e     = '0;
    e.cnt = 4'(m_cnt);
    for (int b = 0; b < 4; b++) begin
      new_ptr[b]       = m_ptr[b];
      e.rid[b*2 +: 2]  = 2'(m_ptr[b]);
      if (iv && (ib == 2'(b))) begin
        // bank held by init: nothing granted
      end else if (sr[b]) begin
        e.st[b]         = 1'b1;
        e.gop[b]        = 1'b1;
        e.rid[b*2 +: 2] = 2'(b);
      end else begin
        best  = -1;
        bestd = 99;
        for (int k = 0; k < 4; k++) begin
          if (lr[k] && (bid[k*2 +: 2] == 2'(b))) begin
            d = (k - m_ptr[b] + 4) % 4;
            if (d < bestd) begin
              bestd = d;
              best  = k;
            end
          end
        end
        if (best >= 0) begin
          e.ld[best]      = 1'b1;
          e.gop[b]        = 1'b1;
          e.rid[b*2 +: 2] = 2'(best);
          new_ptr[b]      = (best + 1) % 4;
        end
      end
    end
    q.push_back(e);
    if (r) begin
      for (int b = 0; b < 4; b++) m_ptr[b] = new_ptr[b];
      if (pc) m_cnt = 0;
      else if (((lr & ~e.ld) != 4'h0) && (m_cnt < 15)) m_cnt = m_cnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Bank ids packed as {pe3, pe2, pe1, pe0}
  function automatic logic [7:0] bids(input int b3, input int b2,
                                      input int b1, input int b0);
    return {2'(b3), 2'(b2), 2'(b1), 2'(b0)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    ld_req         = '0;
    ld_mem_bank_id = '0;
    st_req         = '0;
    init_mem_vld   = 1'b0;
    init_bank_id   = '0;
    perf_clr       = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    step(0, 4'b0000, 8'h00, 4'b0000, 0, 0, 0);
    step(0, 4'b0000, 8'h00, 4'b0000, 0, 0, 0);
    step(1, 4'b0000, 8'h00, 4'b0000, 0, 0, 0);

    // Single load: PE1 -> bank 3, then idle shows ptr[3]=2
    step(1, 4'b0010, bids(0, 0, 3, 0), 4'b0000, 0, 0, 0);
    step(1, 4'b0000, 8'h00, 4'b0000, 0, 0, 0);

    // Round-robin on bank 2, each PE drops after its grant; then wrap to PE0
    step(1, 4'b1111, bids(2, 2, 2, 2), 4'b0000, 0, 0, 0);
    step(1, 4'b1110, bids(2, 2, 2, 2), 4'b0000, 0, 0, 0);
    step(1, 4'b1100, bids(2, 2, 2, 2), 4'b0000, 0, 0, 0);
    step(1, 4'b1000, bids(2, 2, 2, 2), 4'b0000, 0, 0, 0);
    step(1, 4'b0001, bids(2, 2, 2, 2), 4'b0000, 0, 0, 0);

    // Store beats load on bank 2
    step(1, 4'b0001, bids(0, 0, 0, 2), 4'b0100, 0, 0, 0);
    step(1, 4'b0000, 8'h00, 4'b0000, 0, 0, 0);

    // Init blocks bank 1; bank 0 load and bank 2 store proceed
    step(1, 4'b1001, bids(1, 0, 0, 0), 4'b0110, 1, 1, 0);

    // Persistent conflict on bank 0 saturates the counter, then clear
    for (int i = 0; i < 20; i++)
      step(1, 4'b0011, bids(0, 0, 0, 0), 4'b0000, 0, 0, 0);
    step(1, 4'b0011, bids(0, 0, 0, 0), 4'b0000, 0, 0, 1);
    step(1, 4'b0000, 8'h00, 4'b0000, 0, 0, 0);

    // Reset mid-run with ptr[0]=3, then PE0/PE3 conflict on bank 0
    step(1, 4'b0100, bids(0, 0, 0, 0), 4'b0000, 0, 0, 0);
    step(1, 4'b0000, 8'h00, 4'b0000, 0, 0, 0);
    step(0, 4'b1001, bids(0, 0, 0, 0), 4'b0000, 0, 0, 0);
    step(1, 4'b1001, bids(0, 0, 0, 0), 4'b0000, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 99) != 0),
           4'($urandom_range(0, 15)),
           8'($urandom),
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
           ($urandom_range(0, 4) == 0),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 19) == 0));
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_interconnect_ld_st_arbiter
`default_nettype wire
